// File: rtl/dmem_bridge.sv
// dmem_bridge: converts CPU byte-addressed load/store requests into word-addressed accesses
// on the data RAM and the memory-mapped peripheral block.
//
// Ports:
//   clock, reset_n              system clock, asynchronous active-low reset
//   req_valid/req_ready         CPU request handshake
//   req_addr/write/size/...     byte address, direction, size (0 B, 1 H, 2 W), zero-extend flag
//   req_wdata                   right-aligned store data
//   resp_valid/resp_ready       response handshake
//   resp_rdata/resp_fault       aligned, extended load data and fault flag
//   ram_* / mmio_*              device address, byte enables, strobe, write data, write enable, q
//
// A request is accepted in IDLE and drives the selected device combinationally in that cycle.
// The response is produced in WAIT from the device q. If the CPU stalls, it is frozen in HOLD.
module dmem_bridge #(
  parameter logic [15:0] RAM_REGION  = 16'h0000,
  parameter logic [15:0] MMIO_REGION = 16'h8000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_fault,
  output logic [13:0] ram_address,
  output logic [3:0]  ram_byteena,
  output logic        ram_clken,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  input  logic [31:0] ram_q,
  output logic [13:0] mmio_address,
  output logic [3:0]  mmio_byteena,
  output logic        mmio_clken,
  output logic [31:0] mmio_data,
  output logic        mmio_wren,
  input  logic [31:0] mmio_q
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e state_q, state_d;

  // Request decode
  logic        hit_ram, hit_mmio, misaligned, req_fault;
  logic        accept, ram_go, mmio_go;
  logic [3:0]  req_be;
  logic [31:0] req_wrep;

  // Captured request attributes
  logic        sel_mmio_q;
  logic [1:0]  lo_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        write_q;
  logic        fault_q;

  // Last driven device address/data
  logic [13:0] ram_addr_q, mmio_addr_q;
  logic [31:0] ram_data_q, mmio_data_q;

  // Frozen response while the CPU stalls
  logic [31:0] hold_rdata_q;
  logic        hold_fault_q;

  // Load data path
  logic [31:0] q_sel;
  logic [7:0]  q_byte;
  logic [15:0] q_half;
  logic [31:0] ext_rdata;

  // RAM wins if both regions are configured to the same value.
  assign hit_ram  = (req_addr[31:16] == RAM_REGION);
  assign hit_mmio = !hit_ram && (req_addr[31:16] == MMIO_REGION);

  assign misaligned = ((req_size == 2'd1) && req_addr[0]) ||
                      ((req_size == 2'd2) && (req_addr[1:0] != 2'b00));
  assign req_fault  = (req_size == 2'd3) || misaligned || !(hit_ram || hit_mmio);

  // Gated by reset_n so nothing reaches the devices while reset is asserted.
  assign req_ready = reset_n && (state_q == StIdle);
  assign accept    = req_valid && req_ready;
  assign ram_go    = accept && !req_fault && hit_ram;
  assign mmio_go   = accept && !req_fault && hit_mmio;

  always_comb begin
    req_be   = 4'b0000;
    req_wrep = req_wdata;
    unique case (req_size)
      2'd0: begin
        req_be   = 4'b0001 << req_addr[1:0];
        req_wrep = {4{req_wdata[7:0]}};
      end
      2'd1: begin
        req_be   = req_addr[1] ? 4'b1100 : 4'b0011;
        req_wrep = {2{req_wdata[15:0]}};
      end
      2'd2: begin
        req_be   = 4'b1111;
        req_wrep = req_wdata;
      end
      default: begin
        req_be   = 4'b0000;
        req_wrep = req_wdata;
      end
    endcase
  end

  // State register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (accept) state_d = StWait;
      StWait:  state_d = resp_ready ? StIdle : StHold;
      StHold:  if (resp_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Request capture, device hold registers and response hold registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sel_mmio_q   <= 1'b0;
      lo_q         <= 2'b00;
      size_q       <= 2'd0;
      uns_q        <= 1'b0;
      write_q      <= 1'b0;
      fault_q      <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      mmio_addr_q  <= '0;
      mmio_data_q  <= '0;
      hold_rdata_q <= '0;
      hold_fault_q <= 1'b0;
    end else begin
      if (accept) begin
        sel_mmio_q <= hit_mmio;
        lo_q       <= req_addr[1:0];
        size_q     <= req_size;
        uns_q      <= req_unsigned;
        write_q    <= req_write;
        fault_q    <= req_fault;
      end
      if (ram_go) begin
        ram_addr_q <= req_addr[15:2];
        ram_data_q <= req_wrep;
      end
      if (mmio_go) begin
        mmio_addr_q <= req_addr[15:2];
        mmio_data_q <= req_wrep;
      end
      if ((state_q == StWait) && !resp_ready) begin
        hold_rdata_q <= ext_rdata;
        hold_fault_q <= fault_q;
      end
    end
  end

  // Lane selection and extension of the captured device's read data
  assign q_sel  = sel_mmio_q ? mmio_q : ram_q;
  assign q_byte = q_sel[{lo_q, 3'b000} +: 8];
  assign q_half = lo_q[1] ? q_sel[31:16] : q_sel[15:0];

  always_comb begin
    ext_rdata = '0;
    if (!fault_q && !write_q) begin
      unique case (size_q)
        2'd0:    ext_rdata = {{24{q_byte[7] & ~uns_q}}, q_byte};
        2'd1:    ext_rdata = {{16{q_half[15] & ~uns_q}}, q_half};
        2'd2:    ext_rdata = q_sel;
        default: ext_rdata = '0;
      endcase
    end
  end

  // Output logic
  always_comb begin
    resp_valid   = 1'b0;
    resp_rdata   = '0;
    resp_fault   = 1'b0;
    ram_clken    = ram_go;
    ram_wren     = ram_go && req_write;
    ram_byteena  = ram_go ? req_be : 4'b0000;
    ram_address  = ram_go ? req_addr[15:2] : ram_addr_q;
    ram_data     = ram_go ? req_wrep : ram_data_q;
    mmio_clken   = mmio_go;
    mmio_wren    = mmio_go && req_write;
    mmio_byteena = mmio_go ? req_be : 4'b0000;
    mmio_address = mmio_go ? req_addr[15:2] : mmio_addr_q;
    mmio_data    = mmio_go ? req_wrep : mmio_data_q;
    unique case (state_q)
      StWait: begin
        resp_valid = 1'b1;
        resp_rdata = ext_rdata;
        resp_fault = fault_q;
      end
      StHold: begin
        resp_valid = 1'b1;
        resp_rdata = hold_rdata_q;
        resp_fault = hold_fault_q;
      end
      default: begin
        resp_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Self-checking bench for dmem_bridge: table of single transactions plus hand-written
// sequences for response stall and asynchronous reset. Behavioural RAM/MMIO models
// answer one cycle after clken; expected responses go through a scoreboard queue.
module tb_dmem_bridge;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_wdata;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [13:0] ram_address, mmio_address;
  logic [3:0]  ram_byteena, mmio_byteena;
  logic        ram_clken, mmio_clken, ram_wren, mmio_wren;
  logic [31:0] ram_data, mmio_data, ram_q, mmio_q;

  dmem_bridge dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_write(req_write), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault),
    .ram_address(ram_address), .ram_byteena(ram_byteena), .ram_clken(ram_clken),
    .ram_data(ram_data), .ram_wren(ram_wren), .ram_q(ram_q),
    .mmio_address(mmio_address), .mmio_byteena(mmio_byteena), .mmio_clken(mmio_clken),
    .mmio_data(mmio_data), .mmio_wren(mmio_wren), .mmio_q(mmio_q)
  );

  always #5 clock = ~clock;

  // Device models: read-before-write, q valid the cycle after clken
  logic [31:0] ram_mem [64] = '{default: 32'h0};
  logic [31:0] mmio_mem [64] = '{default: 32'h0};
  logic [31:0] ram_q_r = 32'h0, mmio_q_r = 32'h0;
  logic        ram_force = 1'b0;
  logic [31:0] ram_force_val = 32'h0;

  assign ram_q  = ram_force ? ram_force_val : ram_q_r;
  assign mmio_q = mmio_q_r;

  always @(posedge clock) begin
    if (ram_clken) begin
      ram_q_r <= ram_mem[ram_address[5:0]];
      if (ram_wren)
        for (int b = 0; b < 4; b++)
          if (ram_byteena[b]) ram_mem[ram_address[5:0]][8*b +: 8] <= ram_data[8*b +: 8];
    end
    if (mmio_clken) begin
      mmio_q_r <= mmio_mem[mmio_address[5:0]];
      if (mmio_wren)
        for (int b = 0; b < 4; b++)
          if (mmio_byteena[b]) mmio_mem[mmio_address[5:0]][8*b +: 8] <= mmio_data[8*b +: 8];
    end
  end

  // Vector table: dev 0 = none (fault), 1 = RAM, 2 = MMIO
  typedef struct {
    logic [31:0] addr;
    logic        wr;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_fault;
    logic [1:0]  exp_dev;
    logic [3:0]  exp_be;
    logic [31:0] exp_data;
  } vec_t;

  typedef struct {
    logic [31:0] rdata;
    logic        fault;
  } resp_t;

  localparam int NumVecs = 17;
  vec_t  vecs [NumVecs];
  resp_t sb_q [$];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic sb_push(input logic [31:0] rdata, input logic fault);
    resp_t r;
    r.rdata = rdata;
    r.fault = fault;
    sb_q.push_back(r);
  endtask

  task automatic sb_pop_check(input string name);
    resp_t r;
    n_checks++;
    if (sb_q.size() == 0) begin
      n_fail++;
      $display("FAIL %s: got response with empty scoreboard, expected none", name);
    end else begin
      n_checks--;
      r = sb_q.pop_front();
      check({name, "_valid"}, {31'h0, resp_valid}, 32'h1);
      check({name, "_rdata"}, resp_rdata, r.rdata);
      check({name, "_fault"}, {31'h0, resp_fault}, {31'h0, r.fault});
    end
  endtask

  task automatic drive(input vec_t v);
    req_valid    = 1'b1;
    req_addr     = v.addr;
    req_write    = v.wr;
    req_size     = v.size;
    req_unsigned = v.uns;
    req_wdata    = v.wdata;
  endtask

  task automatic check_accept(input string name, input vec_t v);
    check({name, "_req_ready"}, {31'h0, req_ready}, 32'h1);
    check({name, "_ram_clken"}, {31'h0, ram_clken}, {31'h0, v.exp_dev == 2'd1});
    check({name, "_mmio_clken"}, {31'h0, mmio_clken}, {31'h0, v.exp_dev == 2'd2});
    if (v.exp_dev == 2'd1) begin
      check({name, "_ram_be"}, {28'h0, ram_byteena}, {28'h0, v.exp_be});
      check({name, "_ram_addr"}, {18'h0, ram_address}, {18'h0, v.addr[15:2]});
      check({name, "_ram_data"}, ram_data, v.exp_data);
      check({name, "_ram_wren"}, {31'h0, ram_wren}, {31'h0, v.wr});
    end else if (v.exp_dev == 2'd2) begin
      check({name, "_mmio_be"}, {28'h0, mmio_byteena}, {28'h0, v.exp_be});
      check({name, "_mmio_addr"}, {18'h0, mmio_address}, {18'h0, v.addr[15:2]});
      check({name, "_mmio_data"}, mmio_data, v.exp_data);
      check({name, "_mmio_wren"}, {31'h0, mmio_wren}, {31'h0, v.wr});
    end else begin
      check({name, "_no_be"}, {28'h0, ram_byteena | mmio_byteena}, 32'h0);
      check({name, "_no_wren"}, {31'h0, ram_wren | mmio_wren}, 32'h0);
    end
  endtask

  // One full transaction: accept cycle, then response exactly one cycle later.
  task automatic apply_vec(input string name, input vec_t v);
    @(negedge clock);
    drive(v);
    sb_push(v.exp_rdata, v.exp_fault);
    #1;
    check_accept(name, v);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    check({name, "_wait_ready"}, {31'h0, req_ready}, 32'h0);
    check({name, "_wait_clken"}, {31'h0, ram_clken | mmio_clken}, 32'h0);
    sb_pop_check(name);
  endtask

  initial begin
    vec_t v;
    // addr, wr, size, uns, wdata, exp_rdata, exp_fault, exp_dev, exp_be, exp_data
    vecs[0]  = '{32'h8000_0000, 1'b1, 2'd2, 1'b0, 32'h0000_03FF, 32'h0, 1'b0, 2'd2, 4'b1111,
                 32'h0000_03FF};
    vecs[1]  = '{32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0000_03FF, 1'b0, 2'd2, 4'b1111,
                 32'h0};
    vecs[2]  = '{32'h0000_0003, 1'b1, 2'd0, 1'b0, 32'h0000_00A5, 32'h0, 1'b0, 2'd1, 4'b1000,
                 32'hA5A5_A5A5};
    vecs[3]  = '{32'h0000_0003, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFA5, 1'b0, 2'd1, 4'b1000,
                 32'h0};
    vecs[4]  = '{32'h0000_0003, 1'b0, 2'd0, 1'b1, 32'h0, 32'h0000_00A5, 1'b0, 2'd1, 4'b1000,
                 32'h0};
    vecs[5]  = '{32'h0000_0004, 1'b1, 2'd2, 1'b0, 32'h8001_1234, 32'h0, 1'b0, 2'd1, 4'b1111,
                 32'h8001_1234};
    vecs[6]  = '{32'h0000_0006, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF_8001, 1'b0, 2'd1, 4'b1100,
                 32'h0};
    vecs[7]  = '{32'h0000_0006, 1'b0, 2'd1, 1'b1, 32'h0, 32'h0000_8001, 1'b0, 2'd1, 4'b1100,
                 32'h0};
    vecs[8]  = '{32'h0000_0004, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0000_1234, 1'b0, 2'd1, 4'b0011,
                 32'h0};
    vecs[9]  = '{32'h0000_0002, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 4'b0000, 32'h0};
    vecs[10] = '{32'h4000_0000, 1'b1, 2'd2, 1'b0, 32'h1234_5678, 32'h0, 1'b1, 2'd0, 4'b0000,
                 32'h0};
    vecs[11] = '{32'h0000_0000, 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 4'b0000, 32'h0};
    vecs[12] = '{32'h8000_0001, 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, 1'b1, 2'd0, 4'b0000, 32'h0};
    vecs[13] = '{32'h8000_0002, 1'b1, 2'd1, 1'b0, 32'h0000_BEEF, 32'h0, 1'b0, 2'd2, 4'b1100,
                 32'hBEEF_BEEF};
    vecs[14] = '{32'h8000_0000, 1'b0, 2'd2, 1'b0, 32'h0, 32'hBEEF_03FF, 1'b0, 2'd2, 4'b1111,
                 32'h0};
    vecs[15] = '{32'h8000_0002, 1'b0, 2'd0, 1'b0, 32'h0, 32'hFFFF_FFEF, 1'b0, 2'd2, 4'b0100,
                 32'h0};
    vecs[16] = '{32'h0000_0002, 1'b0, 2'd1, 1'b0, 32'h0, 32'hFFFF_A500, 1'b0, 2'd1, 4'b1100,
                 32'h0};

    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_write    = 1'b0;
    req_size     = 2'd0;
    req_unsigned = 1'b0;
    req_wdata    = 32'h0;
    resp_ready   = 1'b1;
    #12 reset_n = 1'b1;

    // Reset state
    @(negedge clock);
    #1;
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    check("rst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("rst_resp_rdata", resp_rdata, 32'h0);
    check("rst_resp_fault", {31'h0, resp_fault}, 32'h0);
    check("rst_clken", {31'h0, ram_clken | mmio_clken}, 32'h0);
    check("rst_be", {28'h0, ram_byteena | mmio_byteena}, 32'h0);

    for (int i = 0; i < NumVecs; i++) apply_vec($sformatf("vec%0d", i), vecs[i]);

    // Response stall: q changes in HOLD must not reach the response; a request held by
    // the CPU meanwhile is ignored until the cycle after the handshake.
    @(negedge clock);
    resp_ready = 1'b0;
    v = '{32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 2'd1, 4'b1111, 32'h0};
    drive(v);
    sb_push(v.exp_rdata, v.exp_fault);
    #1;
    check_accept("hold_acc", v);
    @(posedge clock);
    @(negedge clock);
    v = '{32'h0000_0000, 1'b1, 2'd0, 1'b0, 32'h0000_005A, 32'h0, 1'b0, 2'd1, 4'b0001,
          32'h5A5A_5A5A};
    drive(v);
    #1;
    check("hold_wait_rdata", resp_rdata, 32'h8001_1234);
    check("hold_wait_ready", {31'h0, req_ready}, 32'h0);
    check("hold_wait_clken", {31'h0, ram_clken}, 32'h0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clock);
      ram_force     = 1'b1;
      ram_force_val = 32'hDEAD_BEEF + c;
      #1;
      check("hold_valid", {31'h0, resp_valid}, 32'h1);
      check("hold_rdata", resp_rdata, 32'h8001_1234);
      check("hold_ready", {31'h0, req_ready}, 32'h0);
      check("hold_clken", {31'h0, ram_clken}, 32'h0);
    end
    @(negedge clock);
    ram_force_val = 32'h1111_2222;
    resp_ready    = 1'b1;
    #1;
    sb_pop_check("hold_resp");
    @(negedge clock);
    ram_force = 1'b0;
    sb_push(v.exp_rdata, v.exp_fault);
    #1;
    check_accept("hold_next", v);
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    #1;
    sb_pop_check("hold_next_resp");

    // Asynchronous reset while a response is in WAIT
    @(negedge clock);
    v = '{32'h0000_0004, 1'b0, 2'd2, 1'b0, 32'h0, 32'h8001_1234, 1'b0, 2'd1, 4'b1111, 32'h0};
    drive(v);
    @(posedge clock);
    @(negedge clock);
    #1;
    check("arst_wait_valid", {31'h0, resp_valid}, 32'h1);
    #1 reset_n = 1'b0;
    #1;
    check("arst_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("arst_resp_rdata", resp_rdata, 32'h0);
    check("arst_clken", {31'h0, ram_clken | mmio_clken}, 32'h0);
    check("arst_wren", {31'h0, ram_wren | mmio_wren}, 32'h0);
    check("arst_be", {28'h0, ram_byteena | mmio_byteena}, 32'h0);
    check("arst_ram_addr", {18'h0, ram_address}, 32'h0);
    check("arst_mmio_data", mmio_data, 32'h0);
    @(negedge clock);
    req_valid = 1'b0;
    #2 reset_n = 1'b1;
    @(negedge clock);
    #1;
    check("arst_rel_ready", {31'h0, req_ready}, 32'h1);
    check("arst_rel_valid", {31'h0, resp_valid}, 32'h0);
    apply_vec("arst_after", v);

    check("sb_empty", sb_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dmem_bridge.md
Name: dmem_bridge

Overview:
- Sits directly upstream of the memory-mapped peripheral block and the data RAM.
- Converts CPU data-port load/store requests (byte address, size, sign) into 14-bit word-addressed device accesses (address, byteena, clken, data, wren).
- Returns read data aligned and sign/zero-extended, using a valid/ready response handshake.
- Decodes the address region and flags misaligned or unmapped accesses without touching either device.

Parameters:
- RAM_REGION, 16'h0000, value of req_addr[31:16] that selects the data RAM
- MMIO_REGION, 16'h8000, value of req_addr[31:16] that selects the peripheral block

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  1  CPU request present
- req_ready  out  1  bridge accepts request this cycle
- req_addr  in  32  byte address
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- req_unsigned  in  1  load zero-extends when 1
- req_wdata  in  32  store data, right-aligned
- resp_valid  out  1  response present
- resp_ready  in  1  CPU consumes response
- resp_rdata  out  32  extended load data (0 for stores and faults)
- resp_fault  out  1  misaligned, unmapped or illegal-size access
- ram_address / mmio_address  out  14  word address = req_addr[15:2]
- ram_byteena / mmio_byteena  out  4  byte lane enables
- ram_clken / mmio_clken  out  1  device access strobe
- ram_data / mmio_data  out  32  lane-replicated write data
- ram_wren / mmio_wren  out  1  write enable
- ram_q / mmio_q  in  32  device read data, valid the cycle after clken

Behaviour:

State machine (IDLE, WAIT, HOLD). Reset value is IDLE.

IDLE
- req_ready = 1.
- On req_valid, the request is accepted and state moves to WAIT.
- Device outputs are driven combinationally in the accept cycle. Only the selected device gets clken = 1. wren = req_write & clken.
- Captured into registers: region select, addr[1:0], size, unsigned, write, fault.

Fault conditions
- req_size == 3.
- Half access with addr[0] = 1.
- Word access with addr[1:0] != 0.
- addr[31:16] matching neither region.
- A faulting request drives no clken, but is still accepted and answered.

Byteena
- Byte: 4'b0001 << addr[1:0].
- Half: 4'b0011 when addr[1] = 0, 4'b1100 when addr[1] = 1.
- Word: 4'b1111.

Write data replication
- Byte: {4{wdata[7:0]}}.
- Half: {2{wdata[15:0]}}.
- Word: wdata unchanged.

WAIT
- resp_valid = 1, req_ready = 0. All device clken = 0.
- resp_rdata comes from the q of the captured device:
  - the byte lane selected by addr[1:0], or the halfword selected by addr[1];
  - sign-extended unless unsigned is set;
  - 0 for stores and faults.
- resp_ready = 1: go to IDLE.
- resp_ready = 0: register resp_rdata and resp_fault into the hold registers and go to HOLD.

HOLD
- resp_valid = 1, driven from the hold registers.
- Stays until resp_ready = 1, then goes to IDLE.
- Device q changes in this state must not affect the response.

Throughput and latency
- At most one request every 2 cycles.
- Response appears exactly 1 cycle after acceptance.
- A new request can be accepted in the cycle after the response handshake.

Reset (asynchronous, any time)
- State returns to IDLE.
- resp_valid = 0, resp_fault = 0, resp_rdata = 0.
- All clken, wren and byteena = 0; addresses and data = 0.
- An in-flight response is dropped.
- req_ready = 1 once reset deasserts.

Other rules
- Device outputs when not accessing: clken = 0, wren = 0, byteena = 0. Address and data hold the last driven value.
- Simultaneous events: req_valid during WAIT/HOLD is ignored (req_ready = 0). The request must be held by the CPU.

Test Plan:
- Word store 0x0000_03FF to 0x8000_0000 → mmio_clken = 1, mmio_wren = 1, byteena = 4'b1111, address = 0 in the accept cycle. resp_valid the next cycle with fault = 0. A subsequent word load returns 0x0000_03FF.
- Byte store 0xA5 to 0x0000_0003, then signed byte load → ram_byteena = 4'b1000, ram_data = 0xA5A5A5A5, load returns 0xFFFF_FFA5. Unsigned load returns 0x0000_00A5.
- Half load at 0x0000_0006 with ram_q = 0x8001_1234 → signed returns 0xFFFF_8001, unsigned returns 0x0000_8001.
- Word load at 0x0000_0002, and any access to 0x4000_0000 → no clken on either device, resp_fault = 1, resp_rdata = 0, 1-cycle latency.
- resp_ready held low 3 cycles while ram_q changes → resp_valid stays 1, rdata stays at the original value, req_ready = 0 throughout. Next request is accepted the cycle after resp_ready = 1.
- Assert reset_n = 0 asynchronously during WAIT → resp_valid and all clken/wren drop immediately. After release, req_ready = 1 and the next access completes normally.
